// File: rtl/ws2812_in.sv
// ws2812_in -- WS2812 (NeoPixel) single-wire receiver.
//
// Decodes the serial line into bytes. Each high pulse is timed; when it ends,
// the bit is '1' if the high time is at or above the slice threshold, and '0'
// otherwise. Bits are assembled MSB first. A long low period marks a frame
// reset (latch). After reset the block stays in SYNC and ignores the line
// until it has seen one full reset gap, so it never decodes a frame that it
// joined part-way through.
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   ws2812_data_in  asynchronous serial line
//   t_th_cnt_in     bit slice threshold, units of 2 clk_in (high >= th -> '1')
//   t_hmax_cnt_in   maximum legal high time, units of 2 clk_in
//   t_rst_cnt_in    low time that marks a frame reset, units of 2 clk_in
//   byte_vld_out    1-cycle strobe, byte_data_out valid
//   byte_data_out   last received byte, MSB = first bit on the wire
//   frame_rst_out   1-cycle strobe, frame reset detected
//   err_out         1-cycle strobe, protocol error
module ws2812_in #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             ws2812_data_in,
    input  logic [7:0]       t_th_cnt_in,
    input  logic [7:0]       t_hmax_cnt_in,
    input  logic [RST_W-1:0] t_rst_cnt_in,
    output logic             byte_vld_out,
    output logic [7:0]       byte_data_out,
    output logic             frame_rst_out,
    output logic             err_out
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_e;

    // Input synchronizer followed by one edge-detect flop.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   d_q;
    logic                   d, rise, fall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= '0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ws2812_data_in};
            d_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign d    = sync_q[SYNC_STAGES-1];
    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

    state_e           state_q, state_d;
    logic [8:0]       h_cnt_q, h_cnt_d;
    logic [RST_W:0]   l_cnt_q, l_cnt_d;
    logic [6:0]       sreg_q, sreg_d;
    logic [2:0]       idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [7:0]       data_q, data_d;
    logic             frst_q, frst_d;
    logic             err_q, err_d;

    // Comparisons are made on the counter without its LSB (2-clock units).
    logic [7:0]       h_units;
    logic [RST_W-1:0] l_units;
    logic             bit_v;

    assign h_units = h_cnt_q[8:1];
    assign l_units = l_cnt_q[RST_W:1];
    assign bit_v   = (h_units >= t_th_cnt_in);

    always_comb begin
        state_d = state_q;
        // Both counters run freely and saturate; they are cleared on entry
        // to the phase they measure.
        h_cnt_d = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 9'd1;
        l_cnt_d = (l_cnt_q == '1) ? l_cnt_q : l_cnt_q + 1'b1;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        vld_d   = 1'b0;
        data_d  = data_q;
        frst_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_SYNC: begin
                // Any high time restarts the search for a clean reset gap.
                if (d) begin
                    l_cnt_d = '0;
                end else if (l_units >= t_rst_cnt_in) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    h_cnt_d = '0;
                end
            end
            ST_HIGH: begin
                // An over-long high beats a fall seen in the same cycle.
                if (h_units > t_hmax_cnt_in) begin
                    err_d   = 1'b1;
                    sreg_d  = '0;
                    idx_d   = '0;
                    l_cnt_d = '0;
                    state_d = ST_SYNC;
                end else if (fall) begin
                    sreg_d  = {sreg_q[5:0], bit_v};
                    idx_d   = idx_q + 3'd1;
                    l_cnt_d = '0;
                    state_d = ST_LOW;
                    if (idx_q == 3'd7) begin
                        vld_d  = 1'b1;
                        data_d = {sreg_q, bit_v};
                    end
                end
            end
            ST_LOW: begin
                // A rise beats reaching the reset time in the same cycle.
                if (rise) begin
                    h_cnt_d = '0;
                    state_d = ST_HIGH;
                end else if (l_units >= t_rst_cnt_in) begin
                    frst_d  = 1'b1;
                    err_d   = (idx_q != 3'd0);
                    sreg_d  = '0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_SYNC;
            h_cnt_q <= '0;
            l_cnt_q <= '0;
            sreg_q  <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            data_q  <= 8'h00;
            frst_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            l_cnt_q <= l_cnt_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            frst_q  <= frst_d;
            err_q   <= err_d;
        end
    end

    assign byte_vld_out  = vld_q;
    assign byte_data_out = data_q;
    assign frame_rst_out = frst_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_ws2812_in.sv
module tb_ws2812_in;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        line;
    logic [7:0]  th   = 8'd12;
    logic [7:0]  hmax = 8'd60;
    logic [15:0] trst = 16'd1250;   // 50 us at 50 MHz
    logic        vld, frst, err;
    logic [7:0]  data;

    int checks = 0;
    int errors = 0;

    logic [7:0] bq[$];
    int frc = 0, errc = 0, both = 0;

    ws2812_in #(.SYNC_STAGES(2), .RST_W(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .ws2812_data_in(line),
        .t_th_cnt_in(th), .t_hmax_cnt_in(hmax), .t_rst_cnt_in(trst),
        .byte_vld_out(vld), .byte_data_out(data),
        .frame_rst_out(frst), .err_out(err)
    );

    always #10 clk = ~clk;   // 50 MHz

    always @(negedge clk) begin
        if (vld) bq.push_back(data);
        if (frst) frc++;
        if (err) errc++;
        if (frst && err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] getb(input int i);
        if (i < bq.size()) return {24'd0, bq[i]};
        return 32'hDEAD;
    endfunction

    // T0H = 18 clk (0.36 us), T1H = 35 clk (0.7 us), bit period ~62 clk.
    task automatic send_bit(input logic b);
        line = 1'b1;
        repeat (b ? 35 : 18) @(posedge clk);
        #1 line = 1'b0;
        repeat (b ? 27 : 44) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic gap();   // 60 us low
        line = 1'b0;
        repeat (3000) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        line  = 1'b0;
        #55;
        chk("rst_vld",  {31'd0, vld}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_frst", {31'd0, frst}, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: first gap leaves SYNC silently, then 0xA5
        gap();
        chk("t1_nofrst", frc, 0);
        send_byte(8'hA5);
        repeat (10) @(negedge clk);
        chk("t1_count", bq.size(), 1);
        chk("t1_byte",  getb(0), 32'hA5);
        chk("t1_hold",  {24'd0, data}, 32'hA5);

        // 2: three bytes back to back, then latch
        gap();
        chk("t2_frst0", frc, 1);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h5A);
        gap();
        chk("t2_count", bq.size(), 4);
        chk("t2_b0", getb(1), 32'hFF);
        chk("t2_b1", getb(2), 32'h00);
        chk("t2_b2", getb(3), 32'h5A);
        chk("t2_frst", frc, 2);
        chk("t2_err",  errc, 0);

        // 3: partial byte then latch -> frame reset with error
        send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
        gap();
        chk("t3_count", bq.size(), 4);
        chk("t3_frst",  frc, 3);
        chk("t3_err",   errc, 1);
        chk("t3_both",  both, 1);
        send_byte(8'h3C);
        gap();
        chk("t3_clean", getb(4), 32'h3C);
        chk("t3_err2",  errc, 1);
        chk("t3_frst2", frc, 4);

        // 4: 5 us high exceeds hmax -> error, resync
        line = 1'b1;
        repeat (250) @(posedge clk);
        #1 line = 1'b0;
        repeat (50) @(negedge clk);
        chk("t4_err", errc, 2);
        send_byte(8'hFF);
        gap();
        chk("t4_ignored", bq.size(), 5);
        chk("t4_nofrst",  frc, 4);
        send_byte(8'h81);
        gap();
        chk("t4_byte", getb(5), 32'h81);
        chk("t4_frst", frc, 5);

        // 6: reset in the middle of bit 4
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        line = 1'b1;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_data", {24'd0, data}, 32'h00);
        chk("t6_vld",  {31'd0, vld}, 32'd0);
        chk("t6_frst", {31'd0, frst}, 32'd0);
        chk("t6_err",  {31'd0, err}, 32'd0);
        line = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b1;
        gap();
        chk("t6_nofrst", frc, 5);
        send_byte(8'hC3);
        gap();
        chk("t6_count", bq.size(), 7);
        chk("t6_byte",  getb(6), 32'hC3);

        // 5: traffic straight after reset release is dropped
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        send_byte(8'h12); send_byte(8'h34);
        gap();
        chk("t5_drop",   bq.size(), 7);
        chk("t5_nofrst", frc, 6);
        send_byte(8'h99);
        gap();
        chk("t5_byte", getb(7), 32'h99);
        chk("t5_frst", frc, 7);
        chk("t5_err",  errc, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
